seg_drop_game: RTL and testbench
================================

# seg_drop_game

Parametrised falling-segment game rendered on NDIGITS active-low seven-segment displays. The play field is NDIGITS columns by 3 rows, using the horizontal segments a/g/d of each digit. Pieces spawn on the leftmost digit and fall rightward on a drop tick, and the player can change a piece's row or hard-drop it. Full columns clear and score, the drop rate rises with the level, and a game-over state is restartable. It sits between the board's clock, reset and debounced push-buttons and the HEX outputs.

## Interface
- NDIGITS, 6: number of digits/columns (≥2).
- TICK_DIV, 25_000_000: base drop period in clk cycles (≥8).
- SCORE_W, 8: score width.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  reset, asynchronous, active-low.
- btn_rot  in  1  row-cycle / restart button, synchronous, debounced; rising-edge detected internally.
- btn_drop  in  1  hard-drop button, synchronous, debounced; rising-edge detected internally.
- o_hex  out  7*NDIGITS  digit k at [7k+6:7k], bits {g,f,e,d,c,b,a}, active-low; digit 0 leftmost (spawn side).
- o_score  out  SCORE_W  cleared-column count, saturating.
- o_game_over  out  1  high in OVER.
- o_tick  out  1  one-cycle drop-tick pulse.

## Operation
- Field: cell[c][r], c=0..NDIGITS-1, r=0 (a, top), 1 (g, mid), 2 (d, bottom). Active piece: (pc, pr).
- FSM states:
  - SPAWN: if cell[0][1] is set, go to OVER. Else set (pc,pr)=(0,1), clear the drop flag, go to FALL.
  - FALL: one action per cycle, priority hard-drop step > tick step > rot.
    - btn_drop edge sets the drop flag. While the flag is set, a move attempt happens every cycle.
    - A tick also triggers a move attempt.
    - Move attempt: if pc==NDIGITS-1 or cell[pc+1][pr] is set, lock. Lock sets cell[pc][pr] and goes to CLEAR. Otherwise pc++.
    - btn_rot edge: pr' = (pr==2)?0:pr+1. Applied only if cell[pc][pr'] is clear, else ignored.
    - A rot edge coincident with a tick or drop step is discarded.
  - CLEAR: only the locked column can be full; check column pc only.
    - If full: columns 0..pc-1 shift right by one into 1..pc, column 0 becomes empty, score += 1 (saturating), clear_count += 1 (saturating).
    - Always go to SPAWN next.
  - OVER: field frozen, o_game_over=1. A btn_rot edge clears the field, score and clear_count, then goes to SPAWN. btn_drop is ignored.
- Level and drop period:
  - level = min(clear_count>>2, 3).
  - Drop period P = TICK_DIV >> level.
- Display:
  - Segment lit (bit 0) if its cell is set, or if it is the active piece in FALL.
  - b, c, e, f are off, except in OVER, where all b, c, e, f are lit.
- Edge detect: a one-cycle-delayed copy of each button; edge = btn & ~btn_d.

## Timing
- Reset (async, immediate):
  - Field empty, score=0, clear_count=0, drop flag=0, state=SPAWN, tick counter=0, button history=0.
  - o_hex all 1s, o_score=0, o_game_over=0, o_tick=0.
- Tick counter:
  - Runs in every state. o_tick=1 on the edge where the counter reaches P-1, and the counter wraps to 0.
  - The first tick is registered on the P-th edge after reset release.
  - A level change takes effect at the next wrap.
  - A tick outside FALL has no effect.
- Lock latency: lock edge (FALL→CLEAR), +1 edge CLEAR→SPAWN, +1 edge SPAWN→FALL with the new piece displayed.
- Hard-drop: a piece with k free cells ahead locks k+1 edges after the first drop step.
- o_hex and o_game_over decode combinationally from registered state; o_score is registered.
- Reset asserted mid-game returns to the reset values immediately, regardless of state.

## Test plan
- Reset: hold reset low with buttons toggling -> o_hex all 1s, o_score=0, o_game_over=0. Release -> piece lit at digit 0 segment g after 1 edge.
- Fall/lock (NDIGITS=4, TICK_DIV=8): no input.
  - Ticks on edges 8, 16, 24 move the piece to columns 1, 2, 3.
  - Edge 32 locks cell[3][1]; a new piece appears at (0,1) on edge 34.
- Row cycle and clear:
  - Piece 1 locks at (3,1). Piece 2 gets one rot -> locks at (3,2). Piece 3 gets two rots -> locks at (3,0).
  - Result: o_score=1 and column 3 empty after CLEAR.
  - A rot into an occupied row is ignored.
- Hard drop: press btn_drop on the SPAWN→FALL edge with an empty field (NDIGITS=4) -> lock at (3,1) four edges later, with no tick needed.
- Game over and restart: stack four row-1 pieces without rot.
  - Spawn finds cell[0][1] set -> o_game_over=1, all b/c/e/f lit.
  - btn_rot -> field empty, o_score=0, new piece spawns.
- Level: after 4 clears with TICK_DIV=8, o_tick period = 4 cycles. After 12 or more clears it stays at 1 cycle; score saturates at 255.

Source files
------------

// File: rtl/seg_drop_game.sv
// Falling-segment game on NDIGITS active-low seven-segment digits.
// A 3-row field (segments a/g/d) fills left to right; full columns clear and score.
module seg_drop_game #(
   parameter int NDIGITS  = 6,
   parameter int TICK_DIV = 25_000_000,
   parameter int SCORE_W  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   btn_rot,
   input  logic                   btn_drop,
   output logic [7*NDIGITS-1:0]   o_hex,
   output logic [SCORE_W-1:0]     o_score,
   output logic                   o_game_over,
   output logic                   o_tick
);

   localparam int PCW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam int TW  = $clog2(TICK_DIV);
   localparam logic [PCW-1:0] LAST = PCW'(NDIGITS - 1);

   typedef enum logic [1:0] {SPAWN, FALL, CLEAR, OVER} state_t;

   state_t                    state, state_n;
   logic [NDIGITS-1:0][2:0]   field, field_n;
   logic [PCW-1:0]            pc, pc_n, pc_next;
   logic [1:0]                pr, pr_n, pr_rot;
   logic                      drop_flag, drop_n;
   logic [SCORE_W-1:0]        score, score_n;
   logic [3:0]                clear_cnt, clear_n;
   logic                      rot_d, drop_d, rot_edge, drop_edge;
   logic                      blocked, rot_ok;
   logic [TW-1:0]             tick_cnt, tick_last, per_last_n;
   logic                      tick_now;

   assign rot_edge  = btn_rot & ~rot_d;
   assign drop_edge = btn_drop & ~drop_d;

   // The FSM consumes tick_now directly, so a move lands on the same edge o_tick rises.
   assign tick_now = (tick_cnt == tick_last);

   always_comb begin
      case (clear_cnt[3:2])
         2'd0:    per_last_n = TW'(TICK_DIV - 1);
         2'd1:    per_last_n = TW'((TICK_DIV >> 1) - 1);
         2'd2:    per_last_n = TW'((TICK_DIV >> 2) - 1);
         default: per_last_n = TW'((TICK_DIV >> 3) - 1);
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt  <= '0;
         tick_last <= TW'(TICK_DIV - 1);
         o_tick    <= 1'b0;
      end else begin
         o_tick <= tick_now;
         if (tick_now) begin
            tick_cnt  <= '0;
            tick_last <= per_last_n;
         end else begin
            tick_cnt <= tick_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= SPAWN;
         field     <= '0;
         pc        <= '0;
         pr        <= 2'd1;
         drop_flag <= 1'b0;
         score     <= '0;
         clear_cnt <= '0;
         rot_d     <= 1'b0;
         drop_d    <= 1'b0;
      end else begin
         state     <= state_n;
         field     <= field_n;
         pc        <= pc_n;
         pr        <= pr_n;
         drop_flag <= drop_n;
         score     <= score_n;
         clear_cnt <= clear_n;
         rot_d     <= btn_rot;
         drop_d    <= btn_drop;
      end
   end

   always_comb begin
      state_n = state;
      field_n = field;
      pc_n    = pc;
      pr_n    = pr;
      drop_n  = drop_flag;
      score_n = score;
      clear_n = clear_cnt;
      pc_next = (pc == LAST) ? pc : pc + 1'b1;
      blocked = (pc == LAST) || field[pc_next][pr];
      pr_rot  = (pr == 2'd2) ? 2'd0 : pr + 1'b1;
      rot_ok  = ~field[pc][pr_rot];
      case (state)
         SPAWN: begin
            if (field[0][1]) begin
               state_n = OVER;
            end else begin
               pc_n    = '0;
               pr_n    = 2'd1;
               drop_n  = 1'b0;
               state_n = FALL;
            end
         end
         FALL: begin
            if (drop_edge || drop_flag || tick_now) begin
               if (drop_edge) drop_n = 1'b1;
               if (blocked) begin
                  field_n[pc][pr] = 1'b1;
                  state_n         = CLEAR;
               end else begin
                  pc_n = pc_next;
               end
            end else if (rot_edge && rot_ok) begin
               pr_n = pr_rot;
            end
         end
         CLEAR: begin
            if (&field[pc]) begin
               for (int unsigned c = 1; c < NDIGITS; c++) begin
                  if (c <= 32'(pc)) field_n[PCW'(c)] = field[PCW'(c - 1)];
               end
               field_n[0] = '0;
               if (score != '1)      score_n = score + 1'b1;
               if (clear_cnt != '1)  clear_n = clear_cnt + 1'b1;
            end
            state_n = SPAWN;
         end
         OVER: begin
            if (rot_edge) begin
               field_n = '0;
               score_n = '0;
               clear_n = '0;
               state_n = SPAWN;
            end
         end
         default: state_n = SPAWN;
      endcase
   end

   assign o_score     = score;
   assign o_game_over = (state == OVER);

   for (genvar k = 0; k < NDIGITS; k++) begin : g_dig
      logic [2:0] lit;
      always_comb begin
         lit = field[k];
         if (state == FALL && pc == PCW'(k)) lit[pr] = 1'b1;
      end
      assign o_hex[7*k +: 7] = {~lit[1], ~o_game_over, ~o_game_over, ~lit[2],
                                ~o_game_over, ~o_game_over, ~lit[0]};
   end

endmodule

// File: tb/tb_seg_drop_game.sv
// Directed bench for seg_drop_game: timing of fall/lock/clear on a fast-tick
// instance, and level/score saturation on a slower-tick instance.
module tb_seg_drop_game;

   logic        clk = 1'b0;
   logic        reset_a, reset_b;
   logic        rot_v  [2];
   logic        drop_v [2];
   logic [27:0] hex_v  [2];
   logic        over_v [2];
   logic        tick_v [2];
   logic [7:0]  score_a;
   logic [3:0]  score_b;

   int errors = 0;
   int checks = 0;
   int ecount = 0;

   always #5 clk = ~clk;

   seg_drop_game #(.NDIGITS(4), .TICK_DIV(8), .SCORE_W(8)) dut_a (
      .clk(clk), .reset(reset_a), .btn_rot(rot_v[0]), .btn_drop(drop_v[0]),
      .o_hex(hex_v[0]), .o_score(score_a), .o_game_over(over_v[0]), .o_tick(tick_v[0]));

   seg_drop_game #(.NDIGITS(4), .TICK_DIV(512), .SCORE_W(4)) dut_b (
      .clk(clk), .reset(reset_b), .btn_rot(rot_v[1]), .btn_drop(drop_v[1]),
      .o_hex(hex_v[1]), .o_score(score_b), .o_game_over(over_v[1]), .o_tick(tick_v[1]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      ecount++;
   endtask

   task automatic run_to(input int n);
      while (ecount < n) step();
   endtask

   // lit rows of digit k as {r2,r1,r0}
   function automatic logic [2:0] colbits(input logic [27:0] h, input int k);
      return {~h[7*k+3], ~h[7*k+6], ~h[7*k]};
   endfunction

   // columns 0..2 only ever hold the active piece in the clearing phases
   task automatic find_piece(input int d, output int col, output int row);
      logic [2:0] b;
      col = -1;
      row = -1;
      for (int k = 0; k < 3; k++) begin
         b = colbits(hex_v[d], k);
         if (b != 3'b000) begin
            col = k;
            row = b[0] ? 0 : (b[1] ? 1 : 2);
         end
      end
   endtask

   task automatic place(input int d, input int row);
      int c, r, n;
      n = 0;
      find_piece(d, c, r);
      while (c < 0 && n < 50) begin
         step();
         find_piece(d, c, r);
         n++;
      end
      n = 0;
      while (r != row && c >= 0 && n < 12) begin
         rot_v[d] = 1'b1;
         step();
         rot_v[d] = 1'b0;
         step();
         find_piece(d, c, r);
         n++;
      end
      check("place_row", r, row);
      drop_v[d] = 1'b1;
      step();
      drop_v[d] = 1'b0;
      n = 0;
      find_piece(d, c, r);
      while (c >= 0 && n < 20) begin
         step();
         find_piece(d, c, r);
         n++;
      end
      check("piece_locked", (c < 0), 1);
   endtask

   task automatic clear_col(input int d);
      place(d, 1);
      place(d, 2);
      place(d, 0);
   endtask

   task automatic measure_period(input int d, output int p);
      int n;
      n = 0;
      while (tick_v[d] && n < 1000) begin step(); n++; end
      n = 0;
      while (!tick_v[d] && n < 1000) begin step(); n++; end
      p = 0;
      step();
      p = 1;
      while (!tick_v[d] && p < 1000) begin step(); p++; end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      reset_a = 1'b0;
      reset_b = 1'b0;
      rot_v   = '{1'b0, 1'b0};
      drop_v  = '{1'b0, 1'b0};

      // reset held with buttons toggling
      for (int i = 0; i < 4; i++) begin
         rot_v[0]  = i[0];
         drop_v[0] = ~i[0];
         step();
      end
      check("rst_hex",   hex_v[0],  32'h0FFF_FFFF);
      check("rst_score", score_a,   32'h0);
      check("rst_over",  over_v[0], 32'h0);
      check("rst_tick",  tick_v[0], 32'h0);
      rot_v[0]  = 1'b0;
      drop_v[0] = 1'b0;
      step();
      reset_a = 1'b1;
      ecount  = 0;

      // free fall and lock with TICK_DIV=8
      run_to(1);  check("spawn_e1",  hex_v[0], 32'h0FFF_FFBF);
      run_to(7);  check("tick_e7",   tick_v[0], 32'h0);
                  check("hold_e7",   hex_v[0], 32'h0FFF_FFBF);
      run_to(8);  check("tick_e8",   tick_v[0], 32'h1);
                  check("col1_e8",   hex_v[0], 32'h0FFF_DFFF);
      run_to(9);  check("tick_e9",   tick_v[0], 32'h0);
      run_to(16); check("col2_e16",  hex_v[0], 32'h0FEF_FFFF);
      run_to(24); check("col3_e24",  hex_v[0], 32'h07FF_FFFF);
      run_to(33); check("spawn_e33", hex_v[0], 32'h07FF_FFFF);
      run_to(34); check("piece_e34", hex_v[0], 32'h07FF_FFBF);

      // piece 2: one rot, hard drop to (3,2)
      rot_v[0] = 1'b1;
      run_to(35); check("rot_e35", hex_v[0], 32'h07FF_FFF7);
      rot_v[0]  = 1'b0;
      drop_v[0] = 1'b1;
      run_to(36);
      drop_v[0] = 1'b0;
      run_to(37); check("drop_e37",  hex_v[0], 32'h07FD_FFFF);
      run_to(40); check("stack_e40", hex_v[0], 32'h06FF_FFFF);
      run_to(41); check("piece_e41", hex_v[0], 32'h06FF_FFBF);

      // piece 3: two rots to row 0, hard drop fills and clears column 3
      rot_v[0] = 1'b1;
      run_to(42); check("rot_e42", hex_v[0], 32'h06FF_FFF7);
      rot_v[0] = 1'b0;
      run_to(43);
      rot_v[0] = 1'b1;
      run_to(44); check("rot_e44", hex_v[0], 32'h06FF_FFFE);
      rot_v[0]  = 1'b0;
      drop_v[0] = 1'b1;
      run_to(45);
      drop_v[0] = 1'b0;
      run_to(48); check("full_e48",   hex_v[0], 32'h06DF_FFFF);
                  check("score_e48",  score_a,  32'h0);
      run_to(49); check("clear_e49",  hex_v[0], 32'h0FFF_FFFF);
                  check("score_e49",  score_a,  32'h1);
      run_to(50); check("piece_e50",  hex_v[0], 32'h0FFF_FFBF);

      // piece 4 to (3,2); piece 5 tests discarded and blocked rots
      rot_v[0] = 1'b1;
      run_to(51);
      rot_v[0]  = 1'b0;
      drop_v[0] = 1'b1;
      run_to(52);
      drop_v[0] = 1'b0;
      run_to(56); check("stack_e56", hex_v[0], 32'h0EFF_FFFF);
      run_to(57); check("piece_e57", hex_v[0], 32'h0EFF_FFBF);
      run_to(63);
      rot_v[0] = 1'b1;
      run_to(64); check("rot_on_tick", hex_v[0], 32'h0EFF_DFFF);
      rot_v[0] = 1'b0;
      run_to(81);
      rot_v[0] = 1'b1;
      run_to(82); check("rot_blocked", hex_v[0], 32'h06FF_FFFF);
      rot_v[0] = 1'b0;
      run_to(89); check("lock_e88",  hex_v[0], 32'h06FF_FFFF);
      run_to(90); check("piece_e90", hex_v[0], 32'h06FF_FFBF);

      // stack row 1 to game over
      drop_v[0] = 1'b1; run_to(91); drop_v[0] = 1'b0;
      run_to(95);
      drop_v[0] = 1'b1; run_to(96); drop_v[0] = 1'b0;
      run_to(99);
      drop_v[0] = 1'b1; run_to(100); drop_v[0] = 1'b0;
      run_to(101); check("over_e101", over_v[0], 32'h0);
      run_to(102); check("over_e102", over_v[0], 32'h1);
                   check("over_hex",  hex_v[0],  32'h0022_4489);
      drop_v[0] = 1'b1; run_to(103); drop_v[0] = 1'b0;
      run_to(104); check("over_drop_hex", hex_v[0], 32'h0022_4489);
                   check("over_hold",     over_v[0], 32'h1);
                   check("score_pre_rst", score_a,   32'h1);
      rot_v[0] = 1'b1;
      run_to(105); check("restart_hex",   hex_v[0],  32'h0FFF_FFFF);
                   check("restart_over",  over_v[0], 32'h0);
                   check("restart_score", score_a,   32'h0);
      rot_v[0] = 1'b0;
      run_to(106); check("restart_piece", hex_v[0], 32'h0FFF_FFBF);

      // hard drop from the SPAWN->FALL edge on an empty field
      drop_v[0] = 1'b1;
      run_to(107); check("hd_e107", hex_v[0], 32'h0FFF_DFFF);
      drop_v[0] = 1'b0;
      run_to(111); check("hd_e111", hex_v[0], 32'h07FF_FFFF);
      run_to(112); check("hd_e112", hex_v[0], 32'h07FF_FFBF);

      // four clears raise the level: period 8 -> 4
      place(0, 2);
      place(0, 0);
      for (int i = 0; i < 3; i++) clear_col(0);
      repeat (4) step();
      check("score_4", score_a, 32'h4);
      measure_period(0, p);
      check("period_l1", p, 4);

      // asynchronous reset mid-game
      @(posedge clk);
      #3;
      reset_a = 1'b0;
      #1;
      check("mid_rst_hex",   hex_v[0],  32'h0FFF_FFFF);
      check("mid_rst_score", score_a,   32'h0);
      check("mid_rst_over",  over_v[0], 32'h0);
      check("mid_rst_tick",  tick_v[0], 32'h0);

      // slow-tick instance: level 3 and score saturation
      step();
      reset_b = 1'b1;
      for (int i = 0; i < 15; i++) clear_col(1);
      repeat (4) step();
      check("score_15", score_b, 32'hF);
      clear_col(1);
      repeat (4) step();
      check("score_sat", score_b, 32'hF);
      measure_period(1, p);
      check("period_l3", p, 64);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
